// File: rtl/adc_scan_pkg.sv
// Shared types and arithmetic for the ADC scan sequencer.
// ema_step is the shift-based moving average used for every channel.
package adc_scan_pkg;

    localparam int ADC_W = 10;
    localparam int CH_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        CAPTURE,
        GAP
    } scanState_t;

    // The difference is one bit wider and signed, so the arithmetic shift
    // rounds toward minus infinity and the sum always stays within 0..1023.
    function automatic logic [ADC_W-1:0] ema_step(
        input logic [ADC_W-1:0] y,
        input logic [ADC_W-1:0] x,
        input int               k
    );
        logic signed [ADC_W:0] diff;
        logic signed [ADC_W:0] step;
        logic signed [ADC_W:0] sum;
        diff = $signed({1'b0, x}) - $signed({1'b0, y});
        step = diff >>> k;
        sum  = $signed({1'b0, y}) + step;
        return sum[ADC_W-1:0];
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Handshake between the scan sequencer (master) and the SPI ADC reader (slave).
interface adc_scan_ctrl_if;
    import adc_scan_pkg::*;

    logic             adc_enable;
    logic [CH_W-1:0]  adc_sel;
    logic [ADC_W-1:0] adc_data;
    logic             adc_done;

    modport master (
        output adc_enable,
        output adc_sel,
        input  adc_data,
        input  adc_done
    );

    modport slave (
        input  adc_enable,
        input  adc_sel,
        output adc_data,
        output adc_done
    );

endinterface

// File: rtl/adc_ema_bank.sv
// Per-channel result bank with seeded flags and moving-average update.
// The first sample a channel sees after reset is stored as-is.
module adc_ema_bank
    import adc_scan_pkg::*;
#(
    parameter int FILT_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [CH_W-1:0]  wrAddr,
    input  logic [ADC_W-1:0] wrData,
    input  logic [CH_W-1:0]  rdAddr,
    output logic [ADC_W-1:0] rdData
);

    localparam int DEPTH = 2 ** CH_W;

    logic [ADC_W-1:0] bank_q   [DEPTH];
    logic [DEPTH-1:0] seeded_q;

    // Unwritten addresses stay at zero, so out-of-range reads return 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            seeded_q <= '0;
        end else if (wrEn) begin
            if (seeded_q[wrAddr]) begin
                bank_q[wrAddr] <= ema_step(bank_q[wrAddr], wrData, FILT_SHIFT);
            end else begin
                bank_q[wrAddr]   <= wrData;
                seeded_q[wrAddr] <= 1'b1;
            end
        end
    end

    assign rdData = bank_q[rdAddr];

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin conversion sequencer for the SPI ADC reader, feeding the
// filtered per-channel bank read by the display logic.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int SETTLE     = 8,
    parameter int TIMEOUT    = 1023,
    parameter int FILT_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    adc_scan_ctrl_if.master  adc,
    input  logic [CH_W-1:0]  rd_addr,
    output logic [ADC_W-1:0] rd_data,
    output logic             sample_valid,
    output logic [CH_W-1:0]  sample_ch,
    output logic             sweep_done,
    output logic             timeout_err
);

    localparam logic [CH_W-1:0] CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [9:0]      TO_LAST     = 10'(TIMEOUT - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

    scanState_t       state_q, state_d;
    logic [CH_W-1:0]  chIdx_q, chIdx_d;
    logic [CH_W-1:0]  sel_q, sel_d;
    logic             enable_q, enable_d;
    logic [ADC_W-1:0] latch_q, latch_d;
    logic [9:0]       toCnt_q, toCnt_d;
    logic [7:0]       settleCnt_q, settleCnt_d;
    logic             sampleValid_q, sampleValid_d;
    logic [CH_W-1:0]  sampleCh_q, sampleCh_d;
    logic             sweepDone_q, sweepDone_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic             bankWe;

    // All outputs are registered so enable/sel change only on clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            chIdx_q       <= '0;
            sel_q         <= '0;
            enable_q      <= 1'b0;
            latch_q       <= '0;
            toCnt_q       <= '0;
            settleCnt_q   <= '0;
            sampleValid_q <= 1'b0;
            sampleCh_q    <= '0;
            sweepDone_q   <= 1'b0;
            timeoutErr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            chIdx_q       <= chIdx_d;
            sel_q         <= sel_d;
            enable_q      <= enable_d;
            latch_q       <= latch_d;
            toCnt_q       <= toCnt_d;
            settleCnt_q   <= settleCnt_d;
            sampleValid_q <= sampleValid_d;
            sampleCh_q    <= sampleCh_d;
            sweepDone_q   <= sweepDone_d;
            timeoutErr_q  <= timeoutErr_d;
        end
    end

    // Next-state logic; a done seen on the last allowed WAIT cycle still counts.
    always_comb begin
        state_d       = state_q;
        chIdx_d       = chIdx_q;
        sel_d         = sel_q;
        enable_d      = enable_q;
        latch_d       = latch_q;
        toCnt_d       = toCnt_q;
        settleCnt_d   = settleCnt_q;
        sampleValid_d = 1'b0;
        sampleCh_d    = sampleCh_q;
        sweepDone_d   = 1'b0;
        timeoutErr_d  = timeoutErr_q;
        bankWe        = 1'b0;

        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                if (run && !adc.adc_done) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                sel_d    = chIdx_q;
                enable_d = 1'b1;
                toCnt_d  = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                toCnt_d = toCnt_q + 10'd1;
                if (adc.adc_done) begin
                    latch_d  = adc.adc_data;
                    enable_d = 1'b0;
                    state_d  = CAPTURE;
                end else if (toCnt_q == TO_LAST) begin
                    enable_d     = 1'b0;
                    timeoutErr_d = 1'b1;
                    settleCnt_d  = '0;
                    state_d      = GAP;
                end
            end
            CAPTURE: begin
                bankWe        = 1'b1;
                sampleValid_d = 1'b1;
                sampleCh_d    = chIdx_q;
                settleCnt_d   = '0;
                state_d       = GAP;
            end
            GAP: begin
                enable_d = 1'b0;
                if (settleCnt_q != SETTLE_LAST) begin
                    settleCnt_d = settleCnt_q + 8'd1;
                end else if (!adc.adc_done) begin
                    if (chIdx_q == CH_LAST) begin
                        chIdx_d     = '0;
                        sweepDone_d = 1'b1;
                    end else begin
                        chIdx_d = chIdx_q + CH_W'(1);
                    end
                    state_d = run ? ARM : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    adc_ema_bank #(
        .FILT_SHIFT(FILT_SHIFT)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (bankWe),
        .wrAddr (chIdx_q),
        .wrData (latch_q),
        .rdAddr (rd_addr),
        .rdData (rd_data)
    );

    assign adc.adc_enable = enable_q;
    assign adc.adc_sel    = sel_q;
    assign sample_valid   = sampleValid_q;
    assign sample_ch      = sampleCh_q;
    assign sweep_done     = sweepDone_q;
    assign timeout_err    = timeoutErr_q;

endmodule
